// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit period and
// frame shape constants used by both sides of the serial link.
package uart_pkg;

  // 50 MHz system clock at 115200 baud.
  localparam int UART_CLOCK_BIT_DEFAULT = 434;

  // 8N1 frame shape.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Receiver states. WAIT_IDLE absorbs a break or a bad stop bit until the
  // line returns high, so a line held low never produces repeated frames.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  // Counter value at the centre of the start bit.
  function automatic int half_bit(input int clock_bit);
    return (clock_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input that idles high.
// Reusable for any other asynchronous level input.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops; both reset to the idle level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver. Oversamples the synchronised rx line, confirms the start
// bit at its centre, then samples every following bit one bit period later.
// Delivers each good byte with a one-cycle done pulse; a low stop bit gives a
// one-cycle frame_error pulse instead and leaves data untouched.
//
// There is no handshake: data holds the last good byte until the next good
// frame overwrites it, and done/frame_error are single-cycle strobes that the
// consumer must catch in the cycle they are high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int uart_clock_bit = UART_CLOCK_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       active,
  output logic       done,
  output logic       frame_error
);

  localparam int CW = $clog2(uart_clock_bit);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(uart_clock_bit - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(half_bit(uart_clock_bit));
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [7:0]           data_q;
  logic                 active_q;
  logic                 done_q;
  logic                 ferr_q;

  uart_rx_sync u_sync (
    .clk_i  (clock),
    .rst_ni (reset),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  // Frame FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= 8'h00;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          active_q <= 1'b0;
          if (!rx_s) begin
            state_q  <= START;
            cnt_q    <= '0;
            active_q <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            if (rx_s) begin
              // Line went back high before mid start bit: treat as a glitch.
              state_q  <= IDLE;
              active_q <= 1'b0;
            end else begin
              state_q <= DATA;
              cnt_q   <= '0;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_q[idx_q] <= rx_s;
            cnt_q          <= '0;
            idx_q          <= idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            if (rx_s) begin
              data_q  <= shift_q;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_IDLE: begin
          active_q <= 1'b0;
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign active      = active_q;
  assign done        = done_q;
  assign frame_error = ferr_q;

endmodule
